ifu_icache_sa: RTL
==================

IFU_ICACHE_SA -- requirements
Module: ifu_icache_sa

Interface
REQ-001 SHALL have parameter NUM_SETS, default 4, number of sets (power of 2, >=2).
REQ-002 SHALL have parameter NUM_WAYS, default 4, ways per set (power of 2, >=2).
REQ-003 SHALL have parameter LINE_WIDTH, default 128, bits per cache line.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, CPU address width.
REQ-005 SHALL have parameter OFFSET_WIDTH, default 4, byte-offset bits; INDEX_W=$clog2(NUM_SETS); TAG_W=ADDR_WIDTH-OFFSET_WIDTH-INDEX_W.
REQ-006 SHALL have ports: Clock in 1 clock; Rst_N in 1 asynchronous active-low reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have ports: cpu_reqValidIn in 1 fetch request; cpu_reqAddrIn in ADDR_WIDTH fetch address; cpu_reqReadyOut out 1 cache can accept.
REQ-008 SHALL have ports: cpu_rspValidOut out 1 response valid; cpu_rspAddrOut out ADDR_WIDTH address of returned line; cpu_rspInsLineOut out LINE_WIDTH line data.
REQ-009 SHALL have ports: mem_reqValidOut out 1 fill request; mem_reqLineAddrOut out ADDR_WIDTH-OFFSET_WIDTH line address; mem_reqReadyIn in 1 memory accepts request.
REQ-010 SHALL have ports: mem_rspValidIn in 1 fill data valid; mem_rspLineAddrIn in ADDR_WIDTH-OFFSET_WIDTH line address of fill; mem_rspInsLineIn in LINE_WIDTH fill data.
REQ-011 SHALL have port flushIn in 1: invalidate all lines.

Function
REQ-012 SHALL decode address as offset=[OFFSET_WIDTH-1:0], index=next INDEX_W bits, tag=upper TAG_W bits.
REQ-013 SHALL implement FSM IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL; all state, tag, valid, data and replacement storage in flops.
REQ-014 SHALL assert cpu_reqReadyOut only in IDLE with flushIn low; request accepted when cpu_reqValidIn && cpu_reqReadyOut; address registered; IDLE->LOOKUP.
REQ-015 LOOKUP: all ways of indexed set compared in parallel; hit -> cpu_rspValidOut=1 for exactly one cycle with matching way data, rsp address = registered address; ->IDLE (hit latency 1 cycle after accept).
REQ-016 LOOKUP miss: ->MISS_REQ; mem_reqValidOut held 1 with mem_reqLineAddrOut=registered addr[ADDR_WIDTH-1:OFFSET_WIDTH] until mem_reqReadyIn; then ->MISS_WAIT, mem_reqValidOut=0 next cycle.
REQ-017 MISS_WAIT: mem_rspValidIn with mem_rspLineAddrIn equal to pending line address -> FILL; non-matching responses ignored.
REQ-018 FILL victim: lowest-numbered invalid way in set; if none, way chosen by replacement policy (REQ-026/027); write tag, data, valid=1.
REQ-019 FILL SHALL return the filled line on cpu_rspValidOut in the same cycle the write occurs, then ->IDLE (miss latency = 3 cycles + memory delay).
REQ-020 Replacement state SHALL update on every hit (accessed way) and every fill (victim way).
REQ-021 flushIn in IDLE SHALL clear all valid bits and replacement state next edge; flushIn in other states SHALL be held pending and applied on return to IDLE, before any new accept.
REQ-022 Simultaneous flushIn and cpu_reqValidIn in IDLE: flush wins, request not accepted.
REQ-023 Outputs cpu_rspValidOut, mem_reqValidOut SHALL be registered-state driven, no combinational path from cpu_reqValidIn.

Reset
REQ-024 Rst_N low SHALL asynchronously force state IDLE, all valid bits 0, replacement state 0, pending flush 0, cpu_rspValidOut 0, mem_reqValidOut 0, all address/data outputs 0.
REQ-025 Reset mid-miss SHALL abandon the miss; late mem_rspValidIn after reset SHALL be ignored (state IDLE).

Configuration
REQ-026 With IFU_ICACHE_PLRU_EN defined: per set tree-PLRU of NUM_WAYS-1 bits; on access, nodes along path set to point away from accessed way; victim found by following node bits from root.
REQ-027 Without IFU_ICACHE_PLRU_EN: per set $clog2(NUM_WAYS)-bit round-robin pointer; victim = pointer; pointer increments (wraps) on fill only, hits do not change it.

Verification
REQ-028 Cold miss: addr 0x0000_0040, mem returns line 0xA..A after 5 cycles -> one mem req line addr 0x0000004, rsp valid with 0xA..A, latency 8 cycles.
REQ-029 Hit: re-request 0x0000_0048 -> no mem req, rsp valid 1 cycle after accept, data 0xA..A, rsp addr 0x0000_0048.
REQ-030 Set fill/evict (defaults): fill ways 0-3 of set 0 with tags 1-4, hit tag1, miss tag5 -> PLRU_EN: victim way 2; no PLRU_EN: victim way 0.
REQ-031 Mismatched fill: during MISS_WAIT drive mem_rspValidIn with wrong line addr -> ignored, FSM stays MISS_WAIT until correct addr.
REQ-032 Flush during MISS_WAIT: fill completes and responds, then all lines invalid; re-request same addr -> misses.
REQ-033 Rst_N low during MISS_REQ -> mem_reqValidOut 0 immediately, state IDLE, cpu_reqReadyOut 1 after release.

Source files
------------

// File: rtl/ifu_icache_sa_if.sv
// CPU-side fetch and memory-side fill channels of the set-associative instruction cache.
// The cache attaches through the slave modport; the CPU/memory environment uses master.
interface ifu_icache_sa_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4,
  parameter int LINE_WIDTH   = 128
);
  localparam int LINE_ADDR_W = ADDR_WIDTH - OFFSET_WIDTH;

  logic                   cpu_reqValidIn;
  logic [ADDR_WIDTH-1:0]  cpu_reqAddrIn;
  logic                   cpu_reqReadyOut;
  logic                   cpu_rspValidOut;
  logic [ADDR_WIDTH-1:0]  cpu_rspAddrOut;
  logic [LINE_WIDTH-1:0]  cpu_rspInsLineOut;

  logic                   mem_reqValidOut;
  logic [LINE_ADDR_W-1:0] mem_reqLineAddrOut;
  logic                   mem_reqReadyIn;
  logic                   mem_rspValidIn;
  logic [LINE_ADDR_W-1:0] mem_rspLineAddrIn;
  logic [LINE_WIDTH-1:0]  mem_rspInsLineIn;

  modport slave (
    input  cpu_reqValidIn, cpu_reqAddrIn,
    output cpu_reqReadyOut, cpu_rspValidOut, cpu_rspAddrOut, cpu_rspInsLineOut,
    output mem_reqValidOut, mem_reqLineAddrOut,
    input  mem_reqReadyIn, mem_rspValidIn, mem_rspLineAddrIn, mem_rspInsLineIn
  );

  modport master (
    output cpu_reqValidIn, cpu_reqAddrIn,
    input  cpu_reqReadyOut, cpu_rspValidOut, cpu_rspAddrOut, cpu_rspInsLineOut,
    input  mem_reqValidOut, mem_reqLineAddrOut,
    output mem_reqReadyIn, mem_rspValidIn, mem_rspLineAddrIn, mem_rspInsLineIn
  );
endinterface

// File: rtl/ifu_icache_sa.sv
// Set-associative instruction cache, one outstanding miss, flop-based storage.
// Define IFU_ICACHE_PLRU_EN for tree-PLRU replacement; otherwise a per-set round-robin pointer.
module ifu_icache_sa #(
  parameter int NUM_SETS     = 4,
  parameter int NUM_WAYS     = 4,
  parameter int LINE_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic Clock,
  input  logic Rst_N,
  input  logic flushIn,
  ifu_icache_sa_if.slave bus
);
  localparam int INDEX_W     = $clog2(NUM_SETS);
  localparam int TAG_W       = ADDR_WIDTH - OFFSET_WIDTH - INDEX_W;
  localparam int WAY_W       = $clog2(NUM_WAYS);
  localparam int LINE_ADDR_W = ADDR_WIDTH - OFFSET_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_FILL} state_e;

`ifdef IFU_ICACHE_PLRU_EN
  localparam int REPL_W = NUM_WAYS - 1;

  // Tree nodes are heap-ordered (children of n at 2n+1, 2n+2); a 1 steers toward the upper half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [REPL_W-1:0] tree);
    int   node;
    logic b;
    plru_victim = '0;
    node        = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b = 1'b0;
      for (int n = 0; n < REPL_W; n++) if (n == node) b = tree[n];
      plru_victim[WAY_W-1-lvl] = b;
      node = 2 * node + (b ? 2 : 1);
    end
  endfunction

  function automatic logic [REPL_W-1:0] plru_touch(input logic [REPL_W-1:0] tree,
                                                   input logic [WAY_W-1:0]  way);
    int   node;
    logic b;
    plru_touch = tree;
    node       = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b = way[WAY_W-1-lvl];
      for (int n = 0; n < REPL_W; n++) if (n == node) plru_touch[n] = ~b;
      node = 2 * node + (b ? 2 : 1);
    end
  endfunction
`else
  localparam int REPL_W = WAY_W;
`endif

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LINE_WIDTH-1:0]  fill_line_q;
  logic                   flush_pend_q;
  logic [NUM_WAYS-1:0]    valid_q [NUM_SETS];
  logic [REPL_W-1:0]      repl_q  [NUM_SETS];
  logic [TAG_W-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0]  data_q  [NUM_SETS][NUM_WAYS];

  logic [INDEX_W-1:0]     idx;
  logic [TAG_W-1:0]       addr_tag;
  logic [LINE_ADDR_W-1:0] line_addr;
  logic                   hit, inv_found, accept, fill_match, flush_now, fill_we, repl_upd;
  logic [WAY_W-1:0]       hit_way, inv_way, repl_way, victim_way;
  logic [REPL_W-1:0]      repl_nxt;

  assign idx        = addr_q[OFFSET_WIDTH +: INDEX_W];
  assign addr_tag   = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign line_addr  = addr_q[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign fill_match = bus.mem_rspValidIn && (bus.mem_rspLineAddrIn == line_addr);
  assign flush_now  = (state_q == S_IDLE) && (flushIn || flush_pend_q);
  assign fill_we    = (state_q == S_FILL);

  // Parallel tag compare and invalid-way search; descending loops leave the lowest way selected.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == addr_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

`ifdef IFU_ICACHE_PLRU_EN
  assign repl_way = plru_victim(repl_q[idx]);
  assign repl_upd = fill_we || ((state_q == S_LOOKUP) && hit);
  assign repl_nxt = plru_touch(repl_q[idx], fill_we ? victim_way : hit_way);
`else
  assign repl_way = repl_q[idx];
  assign repl_upd = fill_we;
  assign repl_nxt = repl_q[idx] + 1'b1;
`endif

  assign victim_way = inv_found ? inv_way : repl_way;

  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Outputs decode only registered state, so nothing reaches them from cpu_reqValidIn.
  always_comb begin
    state_d                = state_q;
    bus.cpu_reqReadyOut    = 1'b0;
    bus.cpu_rspValidOut    = 1'b0;
    bus.cpu_rspAddrOut     = '0;
    bus.cpu_rspInsLineOut  = '0;
    bus.mem_reqValidOut    = 1'b0;
    bus.mem_reqLineAddrOut = '0;
    case (state_q)
      S_IDLE: begin
        bus.cpu_reqReadyOut = !flushIn && !flush_pend_q;
        if (bus.cpu_reqValidIn && !flushIn && !flush_pend_q) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          bus.cpu_rspValidOut   = 1'b1;
          bus.cpu_rspAddrOut    = addr_q;
          bus.cpu_rspInsLineOut = data_q[idx][hit_way];
          state_d               = S_IDLE;
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        bus.mem_reqValidOut    = 1'b1;
        bus.mem_reqLineAddrOut = line_addr;
        if (bus.mem_reqReadyIn) state_d = S_MISS_WAIT;
      end
      S_MISS_WAIT: if (fill_match) state_d = S_FILL;
      S_FILL: begin
        bus.cpu_rspValidOut   = 1'b1;
        bus.cpu_rspAddrOut    = addr_q;
        bus.cpu_rspInsLineOut = fill_line_q;
        state_d               = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = bus.cpu_reqReadyOut && bus.cpu_reqValidIn;

  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) begin
      // NOTE: state is updated with <= only, so every flop samples pre-edge values.
      addr_q       <= '0;
      fill_line_q  <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '{default: '0};
      repl_q       <= '{default: '0};
    end else begin
      if (accept) addr_q <= bus.cpu_reqAddrIn;
      if ((state_q == S_MISS_WAIT) && fill_match) fill_line_q <= bus.mem_rspInsLineIn;
      if (flush_now) begin
        valid_q      <= '{default: '0};
        repl_q       <= '{default: '0};
        flush_pend_q <= 1'b0;
      end else begin
        if (fill_we)  valid_q[idx][victim_way] <= 1'b1;
        if (repl_upd) repl_q[idx] <= repl_nxt;
        if (flushIn)  flush_pend_q <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits alone decide whether a way is live.
  always_ff @(posedge Clock) begin
    if (fill_we) begin
      tag_q[idx][victim_way]  <= addr_tag;
      data_q[idx][victim_way] <= fill_line_q;
    end
  end
endmodule
